// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared encodings for the N-wide hazard unit: instruction fields, opcode classes,
// register-field masks, pipeline stall masks and split-issue FSM states.
package hazard_scoreboard_unit_pkg;

  localparam int INST_WIDTH         = 32;
  localparam int NUM_REGISTERS_LOG2 = 5;
  localparam int NUM_PIPE_MASKS     = 4;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;

  typedef logic [NUM_REGISTERS_LOG2-1:0] reg_idx_t;
  typedef logic [5:0]                    opcode_t;
  typedef logic [2:0]                    reg_mask_t;

  localparam reg_mask_t REG_MASK_NONE = 3'b000;
  localparam reg_mask_t REG_MASK_RS   = 3'b001;
  localparam reg_mask_t REG_MASK_RT   = 3'b010;
  localparam reg_mask_t REG_MASK_RD   = 3'b100;

  localparam opcode_t OP_CODE_NOP = 6'b100000;
  localparam opcode_t OP_CODE_JR  = 6'b100001;
  localparam opcode_t OP_CODE_LW  = 6'b100011;
  localparam opcode_t OP_CODE_SW  = 6'b101011;
  localparam opcode_t OP_CODE_LA  = 6'b100100;
  localparam opcode_t OP_CODE_SA  = 6'b101100;

  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC    = 4'b0001;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID = 4'b0010;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SPLIT = 1'b1
  } hsu_state_e;

  typedef struct packed {
    reg_mask_t src;
    reg_mask_t dst;
    logic      is_load;
  } reg_class_t;

  // NOP and unlisted 10xxxx/11xxxx opcodes fall through to "no registers".
  function automatic reg_class_t classify(input opcode_t op);
    reg_class_t c;
    c.src     = REG_MASK_NONE;
    c.dst     = REG_MASK_NONE;
    c.is_load = 1'b0;
    case (op)
      OP_CODE_JR: c.src = REG_MASK_RS;
      OP_CODE_LW: begin
        c.src     = REG_MASK_RS;
        c.dst     = REG_MASK_RT;
        c.is_load = 1'b1;
      end
      OP_CODE_SW: c.src = REG_MASK_RS | REG_MASK_RT;
      OP_CODE_LA: begin
        c.dst     = REG_MASK_RT;
        c.is_load = 1'b1;
      end
      OP_CODE_SA: c.src = REG_MASK_RT;
      default: begin
        if (op[5:4] == 2'b00) begin
          c.src = REG_MASK_RS | REG_MASK_RT;
          c.dst = REG_MASK_RD;
        end else if (op[5:4] == 2'b01) begin
          c.src = REG_MASK_RS;
          c.dst = REG_MASK_RT;
        end
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_reg_class_decode.sv
// Per-slot register class decode: which fields are read/written and whether
// the instruction is a load-class producer tracked by the scoreboard.
module hazard_scoreboard_unit_reg_class_decode
  import hazard_scoreboard_unit_pkg::*;
(
  input  logic [INST_WIDTH-1:0] instruction_i,
  output reg_mask_t             src_mask_o,
  output reg_mask_t             dst_mask_o,
  output logic                  is_load_o,
  output reg_idx_t              rs_o,
  output reg_idx_t              rt_o,
  output reg_idx_t              dst_o
);

  reg_class_t cls;
  reg_idx_t   rd;
  logic       unused_imm;

  assign cls        = classify(instruction_i[OPCODE_LSB +: 6]);
  assign rs_o       = instruction_i[RS_LSB +: NUM_REGISTERS_LOG2];
  assign rt_o       = instruction_i[RT_LSB +: NUM_REGISTERS_LOG2];
  assign rd         = instruction_i[RD_LSB +: NUM_REGISTERS_LOG2];
  assign src_mask_o = cls.src;
  assign dst_mask_o = cls.dst;
  assign is_load_o  = cls.is_load;
  assign dst_o      = (cls.dst == REG_MASK_RD) ? rd : rt_o;
  assign unused_imm = ^instruction_i[RD_LSB-1:0];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// N-wide issue hazard unit: load scoreboard, age-ordered intra-bundle RAW check
// and a split-issue FSM that drains a dependent bundle without re-fetching it.
//
// state    | meaning
// ST_RUN   | fresh bundle each cycle, done bits all clear
// ST_SPLIT | bundle partly issued; done marks slots already sent to ID_EX
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_REGS    = 32,
  parameter int LOAD_LAT    = 1,
  parameter int STALL_CNT_W = 16,
  localparam int OLD_W      = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [ISSUE_WIDTH-1:0]          instr_valid_i,
  input  logic [ISSUE_WIDTH*INST_WIDTH-1:0] instruction_i,
  input  logic [OLD_W-1:0]                oldest_i,
  input  logic                            flush_in_i,
  output logic [ISSUE_WIDTH-1:0]          issue_grant_o,
  output logic [ISSUE_WIDTH-1:0]          slot_flush_o,
  output logic [NUM_PIPE_MASKS-1:0]       stall_mask_o,
  output logic [NUM_REGS-1:0]             busy_vec_o,
  output logic [STALL_CNT_W-1:0]          stall_count_o
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  reg_mask_t src_mask [ISSUE_WIDTH];
  reg_mask_t dst_mask [ISSUE_WIDTH];
  logic      is_load  [ISSUE_WIDTH];
  reg_idx_t  rs       [ISSUE_WIDTH];
  reg_idx_t  rt       [ISSUE_WIDTH];
  reg_idx_t  dst      [ISSUE_WIDTH];

  logic [ISSUE_WIDTH-1:0] raw_dep [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] load_use;
  logic [ISSUE_WIDTH-1:0] live;
  logic [ISSUE_WIDTH-1:0] grant_c;
  logic [ISSUE_WIDTH-1:0] pending;
  logic [ISSUE_WIDTH-1:0] done_q, done_d;

  hsu_state_e state_q, state_d;

  logic [CNT_W-1:0]       cnt_q [NUM_REGS];
  logic [CNT_W-1:0]       cnt_d [NUM_REGS];
  logic [2**NUM_REGISTERS_LOG2-1:0] busy_ext;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
    hazard_scoreboard_unit_reg_class_decode u_dec (
      .instruction_i (instruction_i[k*INST_WIDTH +: INST_WIDTH]),
      .src_mask_o    (src_mask[k]),
      .dst_mask_o    (dst_mask[k]),
      .is_load_o     (is_load[k]),
      .rs_o          (rs[k]),
      .rt_o          (rt[k]),
      .dst_o         (dst[k])
    );

    assign load_use[k] = (((src_mask[k] & REG_MASK_RS) != '0) && busy_ext[rs[k]]) ||
                         (((src_mask[k] & REG_MASK_RT) != '0) && busy_ext[rt[k]]);

    // raw_dep[k][j]: slot k reads a register that slot j writes.
    for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_dep
      assign raw_dep[k][j] = (dst_mask[j] != REG_MASK_NONE) &&
                             ((((src_mask[k] & REG_MASK_RS) != '0) && (rs[k] == dst[j])) ||
                              (((src_mask[k] & REG_MASK_RT) != '0) && (rt[k] == dst[j])));
    end
  end

  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_REGS-1:0] = busy_vec_o;
  end

  assign live    = instr_valid_i & ~done_q;
  assign pending = live & ~grant_c;

  // Walk slots oldest-first; the first live slot that cannot go blocks the rest.
  always_comb begin : prefix_logic
    int   s;
    int   t;
    logic eligible;
    logic blocked;
    grant_c  = '0;
    blocked  = 1'b0;
    eligible = 1'b0;
    s        = 0;
    t        = 0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      s = (int'(oldest_i) + p) % ISSUE_WIDTH;
      if (live[s]) begin
        eligible = !load_use[s];
        for (int q = 0; q < p; q++) begin
          t = (int'(oldest_i) + q) % ISSUE_WIDTH;
          if (live[t] && raw_dep[s][t]) eligible = 1'b0;
        end
        if (eligible && !blocked) grant_c[s] = 1'b1;
        else                      blocked    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    if (flush_in_i) begin
      state_d = ST_RUN;
      done_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if ((grant_c != '0) && (pending != '0)) begin
            state_d = ST_SPLIT;
            done_d  = grant_c;
          end else begin
            done_d  = '0;
          end
        end
        ST_SPLIT: begin
          if ((instr_valid_i & ~(done_q | grant_c)) == '0) begin
            state_d = ST_RUN;
            done_d  = '0;
          end else begin
            done_d  = done_q | grant_c;
          end
        end
        default: begin
          state_d = ST_RUN;
          done_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    issue_grant_o = '0;
    slot_flush_o  = '0;
    stall_mask_o  = '0;
    if (!flush_in_i) begin
      issue_grant_o = grant_c;
      slot_flush_o  = pending;
      if (pending != '0) stall_mask_o = PIPE_REG_PC | PIPE_REG_IF_ID;
    end
  end

  // A load issuing this cycle re-arms its register even if the old count was expiring.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (issue_grant_o[k] && is_load[k] && (rt[k] == reg_idx_t'(r))) begin
          cnt_d[r] = CNT_W'(LOAD_LAT);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy_vec_o[r] = (cnt_q[r] != '0);
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((stall_mask_o != '0) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_count_q <= '0;
    else         stall_count_q <= stall_count_d;
  end

  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (load latency 1 and 3, the
// second with a narrow stall counter) share inputs and track a behavioural model.
module tb_hazard_scoreboard_unit;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b010000;
  localparam logic [5:0] OP_ORI  = 6'b010101;
  localparam logic [5:0] OP_NOP  = 6'b100000;
  localparam logic [5:0] OP_JR   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_LA   = 6'b100100;
  localparam logic [5:0] OP_SA   = 6'b101100;
  localparam logic [5:0] OP_X11  = 6'b110011;
  localparam logic [5:0] OP_X10  = 6'b101111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid;
  logic [31:0] instr [2];
  logic [63:0] bundle;
  logic        oldest;
  logic        flush;

  logic [1:0]  gr0, gr1, sf0, sf1;
  logic [3:0]  sm0, sm1;
  logic [31:0] bv0, bv1;
  logic [15:0] scn0;
  logic [3:0]  scn1;

  int total = 0;
  int bad   = 0;

  // Model state: remaining busy cycles per register, issued-slot flags, split flag.
  int         cnt [2][32];
  logic [1:0] dm [2];
  bit         split [2];
  int         sc [2];
  int         lat [2]   = '{1, 3};
  int         scmax [2] = '{65535, 15};
  bit         last_stall0;
  logic [5:0] op_tab [12] = '{OP_ADD, OP_SUB, OP_ADDI, OP_ORI, OP_NOP, OP_JR,
                              OP_LW, OP_SW, OP_LA, OP_SA, OP_X11, OP_X10};

  assign bundle = {instr[1], instr[0]};

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.ISSUE_WIDTH(2), .NUM_REGS(32), .LOAD_LAT(1), .STALL_CNT_W(16)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(valid), .instruction_i(bundle),
    .oldest_i(oldest), .flush_in_i(flush), .issue_grant_o(gr0), .slot_flush_o(sf0),
    .stall_mask_o(sm0), .busy_vec_o(bv0), .stall_count_o(scn0));

  hazard_scoreboard_unit #(.ISSUE_WIDTH(2), .NUM_REGS(32), .LOAD_LAT(3), .STALL_CNT_W(4)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(valid), .instruction_i(bundle),
    .oldest_i(oldest), .flush_in_i(flush), .issue_grant_o(gr1), .slot_flush_o(sf1),
    .stall_mask_o(sm1), .busy_vec_o(bv1), .stall_count_o(scn1));

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] rand_instr();
    return {op_tab[$urandom_range(0, 11)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  // Registers read (s0, s1) and written (d); -1 means none.
  function automatic void mdecode(input logic [31:0] ins, output int s0, output int s1,
                                  output int d, output bit ld);
    logic [5:0] op;
    int rs, rt, rd;
    op = ins[31:26];
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    s0 = -1; s1 = -1; d = -1; ld = 1'b0;
    if (op == OP_JR) s0 = rs;
    else if (op == OP_LW) begin s0 = rs; d = rt; ld = 1'b1; end
    else if (op == OP_SW) begin s0 = rs; s1 = rt; end
    else if (op == OP_LA) begin d = rt; ld = 1'b1; end
    else if (op == OP_SA) s0 = rt;
    else if (op[5:4] == 2'b00) begin s0 = rs; s1 = rt; d = rd; end
    else if (op[5:4] == 2'b01) begin s0 = rs; d = rt; end
  endfunction

  function automatic logic [1:0] model_grant(input int i);
    logic [1:0] g;
    bit blocked, ok, ld;
    int s, t, s0, s1, d, t0, t1, dt;
    g = 2'b00;
    blocked = 1'b0;
    if (flush) return 2'b00;
    for (int p = 0; p < 2; p++) begin
      s = (int'(oldest) + p) % 2;
      if (valid[s] && !dm[i][s]) begin
        mdecode(instr[s], s0, s1, d, ld);
        ok = 1'b1;
        if (s0 >= 0 && cnt[i][s0] > 0) ok = 1'b0;
        if (s1 >= 0 && cnt[i][s1] > 0) ok = 1'b0;
        for (int q = 0; q < p; q++) begin
          t = (int'(oldest) + q) % 2;
          if (valid[t] && !dm[i][t]) begin
            mdecode(instr[t], t0, t1, dt, ld);
            if (dt >= 0 && (dt == s0 || dt == s1)) ok = 1'b0;
          end
        end
        if (ok && !blocked) g[s] = 1'b1;
        else blocked = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) cnt[i][r] = 0;
      dm[i] = 2'b00;
      split[i] = 1'b0;
      sc[i] = 0;
    end
  endtask

  task automatic check_model();
    logic [1:0]  g, pend;
    logic [3:0]  sm;
    logic [31:0] bv;
    for (int i = 0; i < 2; i++) begin
      g    = model_grant(i);
      pend = flush ? 2'b00 : (valid & ~dm[i] & ~g);
      sm   = (pend != 2'b00) ? 4'b0011 : 4'b0000;
      for (int r = 0; r < 32; r++) bv[r] = (cnt[i][r] > 0);
      chk($sformatf("u%0d_grant", i), 64'((i == 0) ? gr0 : gr1), 64'(g));
      chk($sformatf("u%0d_slot_flush", i), 64'((i == 0) ? sf0 : sf1), 64'(pend));
      chk($sformatf("u%0d_stall_mask", i), 64'((i == 0) ? sm0 : sm1), 64'(sm));
      chk($sformatf("u%0d_busy_vec", i), 64'((i == 0) ? bv0 : bv1), 64'(bv));
      chk($sformatf("u%0d_stall_count", i), (i == 0) ? 64'(scn0) : 64'(scn1), 64'(sc[i]));
    end
  endtask

  task automatic model_update();
    logic [1:0] g, pend, nd;
    int nc [32];
    int s0, s1, d;
    bit ld;
    for (int i = 0; i < 2; i++) begin
      g    = model_grant(i);
      pend = flush ? 2'b00 : (valid & ~dm[i] & ~g);
      if (i == 0) last_stall0 = (pend != 2'b00);
      if (pend != 2'b00 && sc[i] < scmax[i]) sc[i]++;
      for (int r = 0; r < 32; r++) nc[r] = (cnt[i][r] > 0) ? cnt[i][r] - 1 : 0;
      for (int k = 0; k < 2; k++) begin
        if (g[k]) begin
          mdecode(instr[k], s0, s1, d, ld);
          if (ld) nc[d] = lat[i];
        end
      end
      for (int r = 0; r < 32; r++) cnt[i][r] = nc[r];
      if (flush) begin
        split[i] = 1'b0; dm[i] = 2'b00;
      end else if (!split[i]) begin
        if (g != 2'b00 && pend != 2'b00) begin split[i] = 1'b1; dm[i] = g; end
        else dm[i] = 2'b00;
      end else begin
        nd = dm[i] | g;
        if ((valid & ~nd) == 2'b00) begin split[i] = 1'b0; dm[i] = 2'b00; end
        else dm[i] = nd;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    valid = 2'b00;
    oldest = 1'b0;
    flush = 1'b0;
    instr[0] = 32'd0;
    instr[1] = 32'd0;
    last_stall0 = 1'b0;
    model_reset();
    sample();
    chk("reset_busy", 64'(bv0), 64'd0);
    chk("reset_count", 64'(scn0), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load-use, latency 1
    valid = 2'b01; oldest = 1'b0;
    instr[0] = mk(OP_LW, 1, 3, 0); instr[1] = mk(OP_NOP, 0, 0, 0);
    sample(); chk("t1_lw_grant", 64'(gr0), 64'b01); advance();
    instr[0] = mk(OP_ADD, 3, 5, 4);
    sample();
    chk("t1_lu_grant", 64'(gr0), 64'b00);
    chk("t1_lu_stall", 64'(sm0), 64'b0011);
    chk("t1_lu_slot_flush", 64'(sf0), 64'b01);
    chk("t1_lu_busy3", 64'(bv0[3]), 64'd1);
    advance();
    sample();
    chk("t1_go_grant", 64'(gr0), 64'b01);
    chk("t1_go_stall", 64'(sm0), 64'd0);
    chk("t1_go_count", 64'(scn0), 64'd1);
    advance();

    // Intra-bundle RAW, oldest = 0, then independent bundle
    do_reset();
    valid = 2'b11; oldest = 1'b0;
    instr[0] = mk(OP_ADDI, 1, 2, 0); instr[1] = mk(OP_ADD, 2, 7, 6);
    sample(); chk("t2_c0_grant", 64'(gr0), 64'b01); chk("t2_c0_stall", 64'(sm0), 64'b0011); advance();
    sample(); chk("t2_c1_grant", 64'(gr0), 64'b10); chk("t2_c1_stall", 64'(sm0), 64'd0); advance();
    instr[0] = mk(OP_ADD, 2, 3, 1); instr[1] = mk(OP_SUB, 5, 6, 4);
    sample(); chk("t2_indep_grant", 64'(gr0), 64'b11); chk("t2_indep_stall", 64'(sm0), 64'd0); advance();

    // Same dependency with age order starting at slot 1
    oldest = 1'b1;
    instr[1] = mk(OP_ADDI, 1, 2, 0); instr[0] = mk(OP_ADD, 2, 7, 6);
    sample(); chk("t3_c0_grant", 64'(gr0), 64'b10); advance();
    sample(); chk("t3_c1_grant", 64'(gr0), 64'b01); chk("t3_c1_stall", 64'(sm0), 64'd0); advance();

    // Latency 3 load-use on the second instance
    do_reset();
    valid = 2'b01; oldest = 1'b0;
    instr[0] = mk(OP_LW, 1, 8, 0); instr[1] = mk(OP_NOP, 0, 0, 0);
    sample(); chk("t4_lw_grant", 64'(gr1), 64'b01); chk("t4_busy8_pre", 64'(bv1[8]), 64'd0); advance();
    instr[0] = mk(OP_ADD, 8, 2, 9);
    for (int c = 0; c < 3; c++) begin
      sample();
      chk($sformatf("t4_bubble%0d_grant", c), 64'(gr1), 64'b00);
      chk($sformatf("t4_bubble%0d_busy8", c), 64'(bv1[8]), 64'd1);
      advance();
    end
    sample();
    chk("t4_go_grant", 64'(gr1), 64'b01);
    chk("t4_go_busy8", 64'(bv1[8]), 64'd0);
    chk("t4_go_count", 64'(scn1), 64'd3);
    advance();

    // Flush while split, with a load still in flight
    do_reset();
    valid = 2'b11; oldest = 1'b0;
    instr[0] = mk(OP_LW, 1, 3, 0); instr[1] = mk(OP_ADD, 3, 7, 6);
    sample(); chk("t5_c0_grant", 64'(gr0), 64'b01); advance();
    flush = 1'b1;
    sample();
    chk("t5_fl_grant", 64'(gr0), 64'b00);
    chk("t5_fl_slot_flush", 64'(sf0), 64'b00);
    chk("t5_fl_stall", 64'(sm0), 64'd0);
    chk("t5_fl_busy3", 64'(bv0[3]), 64'd1);
    advance();
    flush = 1'b0;
    sample(); chk("t5_after_grant", 64'(gr0), 64'b01); chk("t5_after_busy3", 64'(bv0[3]), 64'd0); advance();

    // Asynchronous reset in the middle of a split
    do_reset();
    valid = 2'b11; oldest = 1'b0;
    instr[0] = mk(OP_LW, 1, 2, 0); instr[1] = mk(OP_ADD, 2, 7, 6);
    sample(); chk("t6_c0_grant", 64'(gr0), 64'b01); advance();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_busy", 64'(bv0), 64'd0);
    chk("t6_rst_count", 64'(scn0), 64'd0);
    chk("t6_rst_grant", 64'(gr0), 64'b01);
    check_model();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random bundles; a stalled bundle is held, as fetch would hold it
    last_stall0 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall0 || $urandom_range(0, 7) == 0) begin
        valid    = 2'($urandom);
        oldest   = 1'($urandom);
        instr[0] = rand_instr();
        instr[1] = rand_instr();
      end
      flush = ($urandom_range(0, 15) == 0);
      sample();
      advance();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
